// File: rtl/conv_pkg.sv
// Shared constants and types for the 3x3 window generator ahead of the convolution stage.
package conv_pkg;

  localparam int DEF_PIX_W = 4;
  localparam int DEF_IMG_W = 32;
  localparam int DEF_IMG_H = 25;

  localparam int OUT_ROWS = DEF_IMG_H - 2;
  localparam int OUT_COLS = DEF_IMG_W - 2;

  // Slot of each window element inside win_out, in units of one pixel.
  localparam int B1 = 0;
  localparam int B2 = 1;
  localparam int B3 = 2;
  localparam int B4 = 3;
  localparam int B5 = 4;
  localparam int B6 = 5;
  localparam int B7 = 6;
  localparam int B8 = 7;
  localparam int B9 = 8;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } win_state_t;

endpackage

// File: rtl/conv_line_buf.sv
// One image row of pixels; combinational read returns the old word when
// the same address is written on the coming edge.
module conv_line_buf #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/conv_window_gen.sv
// Raster-scan pixel stream to 3x3 window stream with (i, j) coordinates.
// Optional macro CONV_WIN_STALL_CNT_EN adds a saturating output-stall counter.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W,
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PIX_W-1:0]   pix_in,
  input  logic               pix_valid,
  output logic               pix_ready,
  output logic [9*PIX_W-1:0] win_out,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [4:0]         win_i,
  output logic [4:0]         win_j,
  output logic               frame_done
`ifdef CONV_WIN_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  win_state_t state, state_nxt;

  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic               accept;
  logic               emit;
  logic               col_last;
  logic               row_last;
  logic               frame_last;
  logic [PIX_W-1:0]   lb0_rd;
  logic [PIX_W-1:0]   lb1_rd;
  logic [3*PIX_W-1:0] tap_cur;
  logic [3*PIX_W-1:0] tap_d1;
  logic [3*PIX_W-1:0] tap_d2;
  logic [9*PIX_W-1:0] win_nxt;

  assign pix_ready  = rst_n && (!win_valid || win_ready);
  assign accept     = pix_valid && pix_ready;
  assign col_last   = (col == CW'(IMG_W - 1));
  assign row_last   = (row == RW'(IMG_H - 1));
  assign frame_last = (state == STREAM) && col_last && row_last;
  assign emit       = accept && (row >= RW'(2)) && (col >= CW'(2));

  conv_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (lb1_rd),
    .rdata (lb0_rd)
  );

  conv_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (pix_in),
    .rdata (lb1_rd)
  );

  // Column tap: lowest slice is the oldest row (row-2), top slice the live pixel.
  assign tap_cur = {pix_in, lb1_rd, lb0_rd};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_d1 <= '0;
      tap_d2 <= '0;
    end else if (accept) begin
      tap_d1 <= tap_cur;
      tap_d2 <= tap_d1;
    end
  end

  always_comb begin
    win_nxt = '0;
    win_nxt[B1*PIX_W +: PIX_W] = tap_d2[0       +: PIX_W];
    win_nxt[B2*PIX_W +: PIX_W] = tap_d1[0       +: PIX_W];
    win_nxt[B3*PIX_W +: PIX_W] = tap_cur[0      +: PIX_W];
    win_nxt[B4*PIX_W +: PIX_W] = tap_d2[PIX_W   +: PIX_W];
    win_nxt[B5*PIX_W +: PIX_W] = tap_d1[PIX_W   +: PIX_W];
    win_nxt[B6*PIX_W +: PIX_W] = tap_cur[PIX_W  +: PIX_W];
    win_nxt[B7*PIX_W +: PIX_W] = tap_d2[2*PIX_W +: PIX_W];
    win_nxt[B8*PIX_W +: PIX_W] = tap_d1[2*PIX_W +: PIX_W];
    win_nxt[B9*PIX_W +: PIX_W] = tap_cur[2*PIX_W +: PIX_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:   if (accept && col_last && (row == RW'(1))) state_nxt = STREAM;
      STREAM: if (accept && frame_last)                  state_nxt = DRAIN;
      DRAIN:  if (!win_valid || win_ready)               state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // Loads only happen while pix_ready, so a held window is never overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_out    <= '0;
      win_i      <= '0;
      win_j      <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else if (emit) begin
      win_out    <= win_nxt;
      win_i      <= 5'(row - RW'(2));
      win_j      <= 5'(col - CW'(2));
      win_valid  <= 1'b1;
      frame_done <= frame_last;
    end else if (win_ready) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end
  end

`ifdef CONV_WIN_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (accept && (row == '0) && (col == '0)) begin
      stall_cnt <= '0;
    end else if (win_valid && !win_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
`endif

endmodule
